// File: rtl/pim_mem_pkg.sv
// Shared definitions for the two-port PIM memory arbiter.
// FSM encoding, default lock length and counter sizing.
package pim_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int LOCK_MAX_DEF = 4;

  // Counter must hold LOCK_MAX itself.
  function automatic int cnt_w(input int lock_max);
    return (lock_max < 1) ? 1 : $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/pim_mem_arbiter_memory.sv
// Single-port RAM with a registered read port.
// Array is never reset; only the output register is.
module memory_pim #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [1<<ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pim_mem_arbiter.sv
// Round-robin arbiter with bounded bursts in front of one RAM.
// Grants are combinational; read data returns one cycle later.
module pim_mem_arbiter
  import pim_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int CW = cnt_w(LOCK_MAX);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_MAX);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t          r_state, w_next;
  logic            r_rr, w_rr_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_rv0, r_rv1;
  logic            w_own, w_oreq, w_xreq, w_keep;
  logic            w_pick, w_tgt, w_has;
  logic            w_gnt0, w_gnt1;
  logic            w_ram_en, w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  assign w_own  = (r_state == OWN1);
  assign w_oreq = w_own ? req1 : req0;
  assign w_xreq = w_own ? req0 : req1;
  assign w_keep = (r_state != IDLE) & w_oreq;
  assign w_pick = (req0 & req1) ? r_rr : req1;

  always_comb begin
    w_next  = r_state;
    w_rr_n  = r_rr;
    w_cnt_n = r_cnt;
    w_tgt   = 1'b0;
    w_has   = 1'b0;
    unique case (1'b1)
      w_keep: begin
        w_has = 1'b1;
        if (r_cnt == LOCK_C && w_xreq) begin
          w_tgt   = ~w_own;
          w_cnt_n = ONE_C;
          w_rr_n  = w_own;
        end else begin
          w_tgt = w_own;
          if (r_cnt != LOCK_C) w_cnt_n = r_cnt + ONE_C;
        end
      end
      (~w_keep & (req0 | req1)): begin
        w_has   = 1'b1;
        w_tgt   = w_pick;
        w_cnt_n = ONE_C;
        w_rr_n  = ~w_pick;
      end
      default: begin
        w_next  = IDLE;
        w_cnt_n = '0;
      end
    endcase
    if (w_has) w_next = w_tgt ? OWN1 : OWN0;
  end

  // Reset masks grants so nothing reaches the RAM.
  assign w_gnt0 = ~rst & w_has & ~w_tgt;
  assign w_gnt1 = ~rst & w_has & w_tgt;

  assign w_ram_en    = w_gnt0 | w_gnt1;
  assign w_ram_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign w_ram_addr  = w_gnt1 ? addr1 : addr0;
  assign w_ram_wdata = w_gnt1 ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rr    <= w_rr_n;
      r_cnt   <= w_cnt_n;
      r_rv0   <= w_gnt0 & ~we0;
      r_rv1   <= w_gnt1 & ~we1;
    end
  end

  memory_pim #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(rdata)
  );

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rv0;
  assign rvalid1 = r_rv1;

endmodule

// File: tb/tb_pim_mem_arbiter.sv
// Bench for pim_mem_arbiter: vector table plus read-data scoreboard.
// Two instances cover LOCK_MAX=4 and LOCK_MAX=1.
module tb_pim_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0, req1, we0, we1;
  logic [9:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic ga0, ga1, va0, va1, gb0, gb1, vb0, vb1;
  logic [15:0] rda, rdb;
  logic sel = 1'b0;
  logic g0, g1, v0, v1;
  logic [15:0] rd;

  always #5 clk = ~clk;

  pim_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .LOCK_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(ga0), .gnt1(ga1), .rvalid0(va0), .rvalid1(va1), .rdata(rda)
  );

  pim_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .LOCK_MAX(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gb0), .gnt1(gb1), .rvalid0(vb0), .rvalid1(vb1), .rdata(rdb)
  );

  assign g0 = sel ? gb0 : ga0;
  assign g1 = sel ? gb1 : ga1;
  assign v0 = sel ? vb0 : va0;
  assign v1 = sel ? vb1 : va1;
  assign rd = sel ? rdb : rda;

  typedef struct packed {
    logic        v;
    logic        tag;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    bit          rs, sl;
    bit          r0, w0;
    logic [9:0]  a0;
    logic [15:0] d0;
    bit          r1, w1;
    logic [9:0]  a1;
    logic [15:0] d1;
    bit          eg0, eg1;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [15:0] mdl[int];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rs, bit sl,
                              bit r0, bit w0, int a0, int d0,
                              bit r1, bit w1, int a1, int d1,
                              bit eg0, bit eg1);
    vec_t v;
    v.rs = rs; v.sl = sl;
    v.r0 = r0; v.w0 = w0; v.a0 = a0[9:0]; v.d0 = d0[15:0];
    v.r1 = r1; v.w1 = w1; v.a1 = a1[9:0]; v.d1 = d1[15:0];
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  function automatic logic [15:0] rdm(input logic [9:0] a);
    if (mdl.exists(int'(a))) return mdl[int'(a)];
    return 16'hxxxx;
  endfunction

  task automatic drv(input bit r0, input bit w0, input logic [9:0] a0,
                     input logic [15:0] d0, input bit r1, input bit w1,
                     input logic [9:0] a1, input logic [15:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic check_rd();
    exp_t e;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk("rvalid0", 32'(v0), 32'(e.v & ~e.tag));
    chk("rvalid1", 32'(v1), 32'(e.v & e.tag));
    if (e.v) chk("rdata", 32'(rd), 32'(e.d));
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    check_rd();
    drv(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
    #1;
    chk("gnt0", 32'(g0), 32'(v.eg0));
    chk("gnt1", 32'(g1), 32'(v.eg1));
    chk("gnt_excl", 32'(g0 & g1), 32'(0));
    if (v.eg0 && !v.w0) sb.push_back({1'b1, 1'b0, rdm(v.a0)});
    else if (v.eg1 && !v.w1) sb.push_back({1'b1, 1'b1, rdm(v.a1)});
    else sb.push_back('0);
    if (v.eg0 && v.w0) mdl[int'(v.a0)] = v.d0;
    if (v.eg1 && v.w1) mdl[int'(v.a1)] = v.d1;
  endtask

  // Write attempts during reset must not land in the RAM.
  task automatic do_reset(input bit s);
    @(negedge clk);
    if (s != sel) mdl.delete();
    sel = s;
    rst = 1'b1;
    drv(1, 1, 10'h010, 16'hDEAD, 1, 1, 10'h010, 16'hDEAD);
    #1;
    chk("rst_gnt0", 32'(g0), 32'(0));
    chk("rst_gnt1", 32'(g1), 32'(0));
    chk("rst_rvalid0", 32'(v0), 32'(0));
    chk("rst_rvalid1", 32'(v1), 32'(0));
    chk("rst_rdata", 32'(rd), 32'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
  endtask

  initial begin
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);

    // write then read on requester 0
    tbl.push_back(mk(1,0, 1,1,'h010,'hA5A5, 0,0,0,0, 1,0));
    tbl.push_back(mk(0,0, 1,0,'h010,0,      0,0,0,0, 1,0));
    tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,0, 0,0));
    // both requesting, lock of 4
    tbl.push_back(mk(1,0, 1,0,'h010,0, 1,0,'h010,0, 1,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0, 1,0,'h010,0, 1,0,'h010,0, 1,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0, 1,0,'h010,0, 1,0,'h010,0, 0,1));
    tbl.push_back(mk(0,0, 1,0,'h010,0, 1,0,'h010,0, 1,0));
    tbl.push_back(mk(0,0, 0,0,0,0,     0,0,0,0,     0,0));
    // req1 alone saturates, then yields at once
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0,0, 0,0,0,0, 1,0,'h010,0, 0,1));
    tbl.push_back(mk(0,0, 1,0,'h010,0, 1,0,'h010,0, 1,0));
    tbl.push_back(mk(0,0, 0,0,0,0,     0,0,0,0,     0,0));
    // read-after-write, top address and cross requester
    tbl.push_back(mk(0,0, 1,1,'h3FF,'hBEEF, 0,0,0,0, 1,0));
    tbl.push_back(mk(0,0, 1,0,'h3FF,0,      0,0,0,0, 1,0));
    tbl.push_back(mk(0,0, 0,0,0,0, 1,1,'h020,'h1234, 0,1));
    tbl.push_back(mk(0,0, 1,0,'h020,0, 0,0,0,0,      1,0));
    tbl.push_back(mk(0,0, 0,0,0,0,     0,0,0,0,      0,0));
    // LOCK_MAX=1 instance: preload, then alternate
    tbl.push_back(mk(1,1, 1,1,'h001,'h1111, 0,0,0,0, 1,0));
    tbl.push_back(mk(0,1, 0,0,0,0, 1,1,'h002,'h2222, 0,1));
    tbl.push_back(mk(1,1, 1,0,'h001,0, 1,0,'h002,0, 1,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,1, 1,0,'h001,0, 1,0,'h002,0,
                       k[0], ~k[0]));
    tbl.push_back(mk(0,1, 0,0,0,0, 0,0,0,0, 0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs) do_reset(tbl[i].sl);
      step(tbl[i]);
    end

    // reset lands while a read is granted mid-burst
    do_reset(0);
    step(mk(0,0, 1,1,'h010,'h5A5A, 1,0,'h010,0, 1,0));
    step(mk(0,0, 1,0,'h010,0,      1,0,'h010,0, 1,0));
    @(negedge clk);
    check_rd();
    drv(1, 0, 10'h010, 16'h0, 1, 0, 10'h010, 16'h0);
    #1;
    chk("mid_gnt0", 32'(g0), 32'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt0", 32'(g0), 32'(0));
    chk("mid_rst_gnt1", 32'(g1), 32'(0));
    sb.delete();
    @(negedge clk);
    chk("drop_rvalid0", 32'(v0), 32'(0));
    chk("drop_rvalid1", 32'(v1), 32'(0));
    chk("drop_rdata", 32'(rd), 32'(0));
    rst = 1'b0;
    #1;
    chk("rel_gnt0", 32'(g0), 32'(1));
    chk("rel_gnt1", 32'(g1), 32'(0));
    sb.push_back({1'b1, 1'b0, 16'h5A5A});
    step(mk(0,0, 1,0,'h010,0, 1,0,'h010,0, 1,0));
    step(mk(0,0, 0,0,0,0,     0,0,0,0,     0,0));
    @(negedge clk);
    check_rd();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pim_mem_arbiter.md
PIM_MEM_ARBITER -- requirements
Module: pim_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, RAM address width.
REQ-003 The block SHALL have parameter LOCK_MAX, default 4, the maximum number of consecutive grants to one owner while the other requester waits.
REQ-004 Port clk: input, 1 bit, single clock; all logic is on the rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Ports req0/req1: input, 1 bit each, access request from requester 0 or 1.
REQ-007 Ports we0/we1: input, 1 bit each, write (1) or read (0) qualifier, valid with req.
REQ-008 Ports addr0/addr1: input, ADDR_WIDTH bits each, access address.
REQ-009 Ports wdata0/wdata1: input, DATA_WIDTH bits each, write data.
REQ-010 Ports gnt0/gnt1: output, 1 bit each, combinational grant; a transfer occurs in a cycle where req and gnt are both high.
REQ-011 Ports rvalid0/rvalid1: output, 1 bit each, read data valid pulse for that requester.
REQ-012 Port rdata: output, DATA_WIDTH bits, read data shared by both requesters and qualified by rvalid0/rvalid1.

Function
REQ-013 At most one of gnt0/gnt1 SHALL be high in any cycle, and gnt SHALL never be high without the matching req.
REQ-014 The FSM SHALL have states IDLE, OWN0 and OWN1, and SHALL use a 1-bit round-robin pointer rr (the requester preferred next) plus a burst counter burst_cnt.
REQ-015 In IDLE, or when the current owner drops req, the grant SHALL go to the single requester if only one is requesting, or to requester rr if both are; the FSM then enters the matching OWNx state with burst_cnt=1.
REQ-016 In OWNx with reqx high, the grant SHALL stay with x and burst_cnt SHALL increment, unless burst_cnt==LOCK_MAX and the other req is high.
REQ-017 In that exception case the grant SHALL pass to the other requester that same cycle, burst_cnt SHALL reset to 1, and rr SHALL point back at x.
REQ-018 If no req is high, the FSM SHALL return to IDLE with gnt0=gnt1=0 and rr left unchanged.
REQ-019 Whenever a grant moves to requester y, rr SHALL become ~y.
REQ-020 If LOCK_MAX=1, the arbiter SHALL alternate every cycle while both requesters are requesting.
REQ-021 The granted port's we, addr and wdata SHALL be muxed to the RAM in the grant cycle; with no grant, RAM we SHALL be 0.
REQ-022 A granted read SHALL produce rdata and a one-cycle rvalidx exactly one cycle after the grant cycle (latency 1, registered RAM output).
REQ-023 A granted write SHALL produce no rvalid.
REQ-024 Back-to-back reads, including alternating requesters, SHALL give one rvalid per cycle with the correct tag.
REQ-025 A read in the cycle after a write to the same address SHALL return the new data.
REQ-026 burst_cnt SHALL saturate at LOCK_MAX and never wrap.

Reset
REQ-027 On rst high, the block SHALL asynchronously set state=IDLE, rr=0, burst_cnt=0, rvalid0=rvalid1=0, rdata=0 and gnt0=gnt1=0.
REQ-028 The block SHALL suppress RAM we while rst is high.
REQ-029 A read granted in the cycle that rst asserts SHALL produce no rvalid.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 After rst deasserts, the first grant SHALL follow REQ-015 with rr=0.

Structure
REQ-032 The state encoding (IDLE/OWN0/OWN1) SHALL be defined as constants in the shared package pim_mem_pkg, and LOCK_MAX width SHALL be derived there via clog2.
REQ-033 The block SHALL instantiate exactly one sub-module, memory_pim, with DATA_WIDTH and ADDR_WIDTH passed through unchanged.

Verification
REQ-034 Scenario: req0 only, writes 0xA5A5 to addr 0x010, then reads addr 0x010 -> gnt0 in both cycles; rvalid0 one cycle after the read grant with rdata=0xA5A5; rvalid1 stays 0.
REQ-035 Scenario: req0 and req1 held high with LOCK_MAX=4 from reset -> grant sequence 0,0,0,0,1,1,1,1,0 and gnt never overlaps.
REQ-036 Scenario: req1 alone for 10 cycles -> gnt1 held all 10 cycles with no forced handoff, and burst_cnt saturates at 4.
REQ-037 Scenario: alternating reads (req0 addr 0x001 holds 0x1111, req1 addr 0x002 holds 0x2222) with LOCK_MAX=1 -> rvalid0/rvalid1 alternate each cycle with the matching data.
REQ-038 Scenario: rst asserted mid-burst while a read is granted -> that read produces no rvalid, gnt drops, and the first grant after release goes to req0 when both are requesting.
REQ-039 Scenario: write 0xBEEF to addr 0x3FF then read addr 0x3FF on the next cycle (wrap-edge address) -> rdata=0xBEEF.
